li_credit_link_arbiter: RTL
===========================

// Module: li_credit_link_arbiter
// PURPOSE
// - Shares one credit-based pipelined link among NUM_SRC senders (e.g. FIR taps feeding a common accumulator).
// - Works with credit_interconnect_reg / pipeline_stage ("credit") chains.
// - Round-robin arbitration, gated by a credit counter that mirrors downstream buffer space.
// - Registered output: one grant (one word) per cycle max; never overruns the receiver.
// PARAMETERS
// - DATA_WIDTH  32  payload bits per word
// - NUM_SRC     4   number of requesters, >=2
// - CREDITS     4   downstream buffer depth = initial credits, >=1
// - Derived: ID_W = $clog2(NUM_SRC); CNT_W = $clog2(CREDITS+1)
// PORTS
// - clock              in   1                   system clock, all state on posedge
// - reset              in   1                   synchronous, active-high
// - i_data             in   NUM_SRC*DATA_WIDTH  src k payload at [k*DATA_WIDTH +: DATA_WIDTH]
// - i_valid            in   NUM_SRC             src k has a word
// - o_ready            out  NUM_SRC             one-hot grant; word k accepted when i_valid[k]&&o_ready[k]
// - o_data             out  DATA_WIDTH          link payload (registered)
// - o_valid            out  1                   link valid (registered)
// - o_grant_id         out  ID_W                source index of current o_data (registered)
// - i_increment_count  in   1                   credit return from receiver, 1 credit per cycle high
// - o_credits          out  CNT_W               current credit count
// - o_credit_err       out  1                   sticky: credit returned while count == CREDITS
// BEHAVIOUR
// - Reset (sync, active-high): o_valid=0, o_data=0, o_grant_id=0, o_credit_err=0.
//   - Credit count = CREDITS; rr_ptr = 0; o_ready = 0 combinationally while reset is high.
//   - In-flight words are dropped; no partial state survives.
// - Grant (combinational, same cycle):
//   - If credits > 0 and any i_valid, grant g = first k with i_valid[k], searching rr_ptr, rr_ptr+1, ... mod NUM_SRC.
//   - o_ready = onehot(g), else 0. o_ready[k] is never asserted unless i_valid[k].
//   - Senders must hold i_data/i_valid until accepted.
//   - Credits are only counted at posedge, so a credit returned this cycle is usable next cycle, never the same cycle.
// - On a grant (posedge):
//   - o_valid <= 1; o_data <= word g; o_grant_id <= g; rr_ptr <= (g+1) mod NUM_SRC (wraps NUM_SRC-1 -> 0).
// - Without a grant: o_valid <= 0; o_data and o_grant_id hold; rr_ptr holds.
// - Latency: 1 cycle from acceptance to o_valid. Throughput: 1 word/cycle while credits last.
// - Credit update: cnt <= cnt - grant + i_increment_count.
//   - Simultaneous grant and return: count unchanged.
//   - cnt==0: no grant; a return in that cycle makes cnt=1 next cycle.
//   - Return at cnt==CREDITS with no grant: cnt saturates at CREDITS and o_credit_err <= 1 (sticky until reset).
// - Fairness: with all sources valid and credits available, grants cycle 0,1,...,NUM_SRC-1,0.
//   - No source waits more than NUM_SRC grants.
// CONFIGURATION
// - LINK_ARB_STALL_CNT_EN defined:
//   - Adds output port o_stall_count [31:0], reset 0.
//   - Increments (wrapping at 2^32) each cycle where |i_valid && cnt==0.
// - LINK_ARB_STALL_CNT_EN undefined: port and counter absent. All other behaviour identical.
// TESTING
// - Reset, then src0 only valid with 0xA5 -> o_ready=0001 same cycle; next cycle o_valid=1, o_data=0xA5, o_grant_id=0, o_credits=3.
// - CREDITS=4, all 4 srcs valid, no returns -> grants 0,1,2,3 on 4 consecutive cycles.
//   - o_ready=0 afterwards; o_credits=0.
//   - With STALL_CNT_EN, o_stall_count increments each following cycle.
// - Credits=0 with srcs valid, pulse i_increment_count 1 cycle -> next cycle o_credits=1.
//   - Exactly one grant, to the source at rr_ptr (src0 after wrap).
// - Steady grant plus i_increment_count every cycle -> o_credits constant; o_valid high every cycle; no credit error.
// - Idle at o_credits=4, pulse i_increment_count -> o_credits stays 4; o_credit_err=1 and remains 1 until reset.
// - Mid-burst reset with 2 credits outstanding -> next cycle o_valid=0, o_credits=4, o_credit_err=0.
//   - First grant after reset goes to src0.

Source files
------------

// File: rtl/li_credit_link_arbiter.sv
// Round-robin arbiter sharing one credit-based link among NUM_SRC senders.
// Optional stall counter enabled by defining LINK_ARB_STALL_CNT_EN.
module li_credit_link_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int CREDITS    = 4,
  localparam int ID_W      = $clog2(NUM_SRC),
  localparam int CNT_W     = $clog2(CREDITS + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_SRC-1:0]            i_valid,
  output logic [NUM_SRC-1:0]            o_ready,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_valid,
  output logic [ID_W-1:0]               o_grant_id,
  input  logic                          i_increment_count,
  output logic [CNT_W-1:0]              o_credits,
`ifdef LINK_ARB_STALL_CNT_EN
  output logic [31:0]                   o_stall_count,
`endif
  output logic                          o_credit_err
);

  logic [CNT_W-1:0]      cnt;
  logic [ID_W-1:0]       rr_ptr;
  logic                  grant_p0;
  logic [ID_W-1:0]       gnt_id_p0;
  logic [DATA_WIDTH-1:0] gnt_word_p0;

  // Counter mirrors receiver space; a return with the counter already full is absorbed.
  function automatic logic [CNT_W-1:0] credit_next(input logic [CNT_W-1:0] c,
                                                   input logic take,
                                                   input logic give);
    logic [CNT_W-1:0] n;
    n = c;
    if (take && !give)
      n = c - CNT_W'(1);
    else if (give && !take && c != CNT_W'(CREDITS))
      n = c + CNT_W'(1);
    return n;
  endfunction

  // Stage p0: combinational round-robin search starting at rr_ptr
  always_comb begin
    int idx;
    idx         = 0;
    grant_p0    = 1'b0;
    gnt_id_p0   = '0;
    gnt_word_p0 = '0;
    if (!reset && cnt != '0) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        idx = (int'(rr_ptr) + i) % NUM_SRC;
        if (!grant_p0 && i_valid[idx]) begin
          grant_p0    = 1'b1;
          gnt_id_p0   = ID_W'(idx);
          gnt_word_p0 = i_data[idx*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign o_ready   = grant_p0 ? (NUM_SRC'(1) << gnt_id_p0) : '0;
  assign o_credits = cnt;

  // Stage p1: registered link output and credit bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_grant_id   <= '0;
      o_credit_err <= 1'b0;
      cnt          <= CNT_W'(CREDITS);
      rr_ptr       <= '0;
    end else begin
      o_valid <= grant_p0;
      if (grant_p0) begin
        o_data     <= gnt_word_p0;
        o_grant_id <= gnt_id_p0;
        rr_ptr     <= (gnt_id_p0 == ID_W'(NUM_SRC - 1)) ? '0 : gnt_id_p0 + ID_W'(1);
      end
      cnt <= credit_next(cnt, grant_p0, i_increment_count);
      if (i_increment_count && !grant_p0 && cnt == CNT_W'(CREDITS))
        o_credit_err <= 1'b1;
    end
  end

`ifdef LINK_ARB_STALL_CNT_EN
  always_ff @(posedge clock) begin
    if (reset)
      o_stall_count <= '0;
    else if (|i_valid && cnt == '0)
      o_stall_count <= o_stall_count + 32'd1;
  end
`endif

endmodule
